// File: rtl/window_scan_controller.sv
// window_scan_controller
// Walks a 3x3 window across an IMG_W x IMG_H frame in raster order.
// Each column step is one windowBuffer shift followed by three pixel reads
// (rows row_top, row_top+1 and row_top+2). Once three columns are loaded,
// the full window is offered downstream on a valid/ready handshake.
// Moving to a new row band reloads three columns before the next window.

module window_scan_controller #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    input  logic              shift_done,
    output logic              start_read,
    output logic [ADDR_W-1:0] read_addr,
    output logic [3:0]        read_slot,
    input  logic              read_done,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [15:0]       win_x,
    output logic [15:0]       win_y
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        READ,
        EMIT,
        DONE
    } state_t;

    // Scan limits. LAST_ROW_TOP is the last top row of a 3-row band that fits in the frame.
    localparam logic [15:0]       LAST_COL     = 16'(IMG_W - 1);
    localparam logic [15:0]       LAST_ROW_TOP = 16'(IMG_H - 3);
    localparam logic [15:0]       FIRST_EMIT   = 16'd2;
    localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STRIDE2  = ADDR_W'(2 * IMG_W);

    state_t state_q, state_d;

    // Column currently being loaded, or presented as the right edge of the window in EMIT.
    logic [15:0] col_q, col_d;

    // Top row of the current 3-row band.
    logic [15:0] rowTop_q, rowTop_d;

    // Row within the band being read: 0, 1 or 2.
    logic [1:0] rowSel_q, rowSel_d;

    // Address of pixel (rowTop, 0). It is kept as a running sum so no multiplier is needed.
    logic [ADDR_W-1:0] rowBase_q, rowBase_d;

    // Offset of the selected band row from rowBase: 0, IMG_W or 2*IMG_W.
    logic [ADDR_W-1:0] rowOffset;

    // Decision terms for the end of a column and the end of a window.
    logic lastRowOfBand;
    logic windowLoaded;
    logic moreCols;
    logic moreRows;

    // State and scan counters. Reset is synchronous, and a reset mid-scan abandons any request.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            rowTop_q  <= '0;
            rowSel_q  <= '0;
            rowBase_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            rowTop_q  <= rowTop_d;
            rowSel_q  <= rowSel_d;
            rowBase_q <= rowBase_d;
        end
    end

    // Decode the scan position into the branch conditions used by the FSM.
    always_comb begin
        lastRowOfBand = (rowSel_q == 2'd2);
        windowLoaded  = (col_q >= FIRST_EMIT);
        moreCols      = (col_q < LAST_COL);
        moreRows      = (rowTop_q < LAST_ROW_TOP);
    end

    // Select the band-row offset without multiplying.
    always_comb begin
        rowOffset = '0;
        case (rowSel_q)
            2'd0:    rowOffset = '0;
            2'd1:    rowOffset = ROW_STRIDE;
            default: rowOffset = ROW_STRIDE2;
        endcase
    end

    // Next-state logic. Handshake inputs are only honoured in their matching state.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        rowTop_d  = rowTop_q;
        rowSel_d  = rowSel_q;
        rowBase_d = rowBase_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    col_d     = '0;
                    rowTop_d  = '0;
                    rowSel_d  = '0;
                    rowBase_d = '0;
                end
            end

            SHIFT: begin
                if (shift_done) begin
                    rowSel_d = '0;
                    state_d  = READ;
                end
            end

            READ: begin
                if (read_done) begin
                    if (!lastRowOfBand) begin
                        rowSel_d = rowSel_q + 2'd1;
                    end else if (windowLoaded) begin
                        state_d = EMIT;
                    end else begin
                        col_d   = col_q + 16'd1;
                        state_d = SHIFT;
                    end
                end
            end

            EMIT: begin
                if (win_ready) begin
                    if (moreCols) begin
                        col_d   = col_q + 16'd1;
                        state_d = SHIFT;
                    end else if (moreRows) begin
                        rowTop_d  = rowTop_q + 16'd1;
                        rowBase_d = rowBase_q + ROW_STRIDE;
                        col_d     = '0;
                        state_d   = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs. Each request is decoded from a single state, so at most one is high at a time.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        start_shift = 1'b0;
        shift_direc = 2'b00;
        start_read  = 1'b0;
        read_addr   = '0;
        read_slot   = 4'd0;
        win_valid   = 1'b0;
        win_x       = '0;
        win_y       = '0;

        case (state_q)
            SHIFT: begin
                busy        = 1'b1;
                start_shift = 1'b1;
                shift_direc = 2'b01;
            end

            READ: begin
                busy       = 1'b1;
                start_read = 1'b1;
                read_addr  = rowBase_q + rowOffset + ADDR_W'(col_q);
                read_slot  = 4'd6 + {2'b00, rowSel_q};
            end

            EMIT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                win_x     = col_q - 16'd1;
                win_y     = rowTop_q + 16'd1;
            end

            DONE: begin
                done = 1'b1;
            end

            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_window_scan_controller.sv
// tb_window_scan_controller
// Scoreboard bench for window_scan_controller on a 5x4 frame.
// Stimulus pushes the expected reads, windows and done pulse into queues.
// A negedge monitor pops an entry and compares it on every accepted handshake.
// A small windowBuffer model answers shifts at once and reads after readDelay cycles.

module tb_window_scan_controller;

    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 16;

    typedef struct {
        int addr;
        int slot;
    } rd_t;

    typedef struct {
        int x;
        int y;
    } win_t;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              start_shift;
    logic [1:0]        shift_direc;
    logic              shift_done;
    logic              start_read;
    logic [ADDR_W-1:0] read_addr;
    logic [3:0]        read_slot;
    logic              read_done;
    logic              win_valid;
    logic              win_ready;
    logic [15:0]       win_x;
    logic [15:0]       win_y;

    logic strayShift;
    int   readDelay;
    int   waitCnt;

    int tests;
    int fails;
    int negCount;
    int startNeg;
    int firstWinExp;
    bit winSeen;

    rd_t  expRead[$];
    win_t expWin[$];
    bit   expDone[$];

    bit          prevReadPend;
    logic [15:0] prevAddr;
    logic [3:0]  prevSlot;
    bit          prevWinPend;
    logic [15:0] prevX;
    logic [15:0] prevY;

    // Hand-computed read addresses for a full 5x4 frame: two row bands of five columns.
    int rdAddr[30] = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 9, 14,
                       5, 10, 15, 6, 11, 16, 7, 12, 17, 8, 13, 18, 9, 14, 19};
    int wX[6] = '{1, 2, 3, 1, 2, 3};
    int wY[6] = '{1, 1, 1, 2, 2, 2};

    window_scan_controller #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .start_shift(start_shift),
        .shift_direc(shift_direc),
        .shift_done (shift_done),
        .start_read (start_read),
        .read_addr  (read_addr),
        .read_slot  (read_slot),
        .read_done  (read_done),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_x      (win_x),
        .win_y      (win_y)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // windowBuffer model: shifts complete in the same cycle, reads after readDelay wait cycles.
    assign shift_done = start_shift | strayShift;
    assign read_done  = start_read && (waitCnt >= readDelay);

    // Count the wait cycles of the current read request.
    always @(posedge clk) begin
        if (start_read && !read_done) waitCnt <= waitCnt + 1;
        else waitCnt <= 0;
    end

    // Compare one value and report it when it is wrong.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Record a failure that has no value to compare, such as a timeout or an unexpected transfer.
    task automatic failEvent(input string name);
        tests = tests + 1;
        fails = fails + 1;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    // Monitor: compare accepted transfers with the scoreboard and check that held requests stay stable.
    always @(negedge clk) begin
        negCount = negCount + 1;
        if (!n_rst) begin
            prevReadPend = 1'b0;
            prevWinPend  = 1'b0;
        end else begin
            checkOutput("onehot_req", 32'($countones({start_shift, start_read, win_valid}) <= 1), 32'd1);
            checkOutput("shift_direc", 32'(shift_direc), start_shift ? 32'd1 : 32'd0);

            if (prevReadPend) begin
                checkOutput("read_hold_req", 32'(start_read), 32'd1);
                checkOutput("read_hold_addr", 32'(read_addr), 32'(prevAddr));
                checkOutput("read_hold_slot", 32'(read_slot), 32'(prevSlot));
            end
            if (prevWinPend) begin
                checkOutput("win_hold_valid", 32'(win_valid), 32'd1);
                checkOutput("win_hold_x", 32'(win_x), 32'(prevX));
                checkOutput("win_hold_y", 32'(win_y), 32'(prevY));
            end

            if (start_read && read_done) begin
                if (expRead.size() == 0) begin
                    failEvent("unexpected_read");
                end else begin
                    rd_t e;
                    e = expRead.pop_front();
                    checkOutput("read_addr", 32'(read_addr), 32'(e.addr));
                    checkOutput("read_slot", 32'(read_slot), 32'(e.slot));
                end
            end

            if (win_valid && !winSeen && firstWinExp != 0) begin
                winSeen = 1'b1;
                checkOutput("first_win_cycle", 32'(negCount - startNeg), 32'(firstWinExp));
            end

            if (win_valid && win_ready) begin
                if (expWin.size() == 0) begin
                    failEvent("unexpected_window");
                end else begin
                    win_t w;
                    w = expWin.pop_front();
                    checkOutput("win_x", 32'(win_x), 32'(w.x));
                    checkOutput("win_y", 32'(win_y), 32'(w.y));
                end
            end

            if (done) begin
                if (expDone.size() == 0) begin
                    failEvent("unexpected_done");
                end else begin
                    void'(expDone.pop_front());
                    checkOutput("busy_at_done", 32'(busy), 32'd0);
                    checkOutput("windows_left_at_done", 32'(expWin.size()), 32'd0);
                end
            end

            prevReadPend = start_read && !read_done;
            prevAddr     = read_addr;
            prevSlot     = read_slot;
            prevWinPend  = win_valid && !win_ready;
            prevX        = win_x;
            prevY        = win_y;
        end
    end

    // Load the scoreboard with one full frame of reads, windows and a single done pulse.
    task automatic pushFrame();
        for (int i = 0; i < 30; i++) begin
            rd_t e;
            e.addr = rdAddr[i];
            e.slot = 6 + (i % 3);
            expRead.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            win_t w;
            w.x = wX[i];
            w.y = wY[i];
            expWin.push_back(w);
        end
        expDone.push_back(1'b1);
    endtask

    // Pulse start for one clock and note which negedge is the first cycle after the start edge.
    task automatic pulseStart(input int firstWin);
        firstWinExp = firstWin;
        winSeen     = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        startNeg = negCount;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Check that every output is zero, as after reset.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_reqs"}, 32'({start_shift, start_read, win_valid}), 32'd0);
        checkOutput({tag, "_direc"}, 32'(shift_direc), 32'd0);
        checkOutput({tag, "_addr"}, 32'(read_addr), 32'd0);
        checkOutput({tag, "_slot"}, 32'(read_slot), 32'd0);
        checkOutput({tag, "_winxy"}, {win_x, win_y}, 32'd0);
    endtask

    // Scan one full frame. Options: stall the first window, or inject start and a stray shift_done while busy.
    task automatic applyStimulus(input int delay, input int firstWin, input bit stallFirst, input bit poke);
        bit gotDone;
        bit stalled;
        bit strayDone;
        logic [15:0] hx;
        logic [15:0] hy;
        readDelay = delay;
        win_ready = !stallFirst;
        gotDone   = 1'b0;
        stalled   = 1'b0;
        strayDone = 1'b0;
        pushFrame();
        pulseStart(firstWin);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            start      = 1'b0;
            strayShift = 1'b0;
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (stallFirst && !stalled && win_valid) begin
                stalled = 1'b1;
                hx = win_x;
                hy = win_y;
                for (int k = 1; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    checkOutput("stall_valid", 32'(win_valid), 32'd1);
                    checkOutput("stall_xy", {win_x, win_y}, {hx, hy});
                    checkOutput("stall_no_req", 32'({start_shift, start_read}), 32'd0);
                end
                @(posedge clk);
                #1;
                win_ready = 1'b1;
            end
            if (poke && cyc == 20 && busy) start = 1'b1;
            if (poke && !strayDone && cyc > 5 && start_read) begin
                strayShift = 1'b1;
                strayDone  = 1'b1;
            end
        end
        if (!gotDone) failEvent("frame_timeout");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
        checkOutput("reads_left", 32'(expRead.size()), 32'd0);
        checkOutput("windows_left", 32'(expWin.size()), 32'd0);
        checkOutput("done_left", 32'(expDone.size()), 32'd0);
        readDelay = 0;
        win_ready = 1'b1;
    endtask

    // Start a frame and reset it while it reads the second window column (address 8).
    task automatic applyAbort();
        bit hit;
        hit = 1'b0;
        readDelay = 0;
        pushFrame();
        pulseStart(13);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk);
            #1;
            if (start_read && read_addr == 16'd8) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) failEvent("abort_point_timeout");
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        expRead.delete();
        expWin.delete();
        expDone.delete();
        firstWinExp = 0;
        checkIdleOutputs("abort_reset");
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("abort_idle");
    endtask

    // Main sequence.
    initial begin
        tests       = 0;
        fails       = 0;
        negCount    = 0;
        startNeg    = 0;
        firstWinExp = 0;
        winSeen     = 1'b0;
        n_rst       = 1'b0;
        start       = 1'b0;
        win_ready   = 1'b1;
        strayShift  = 1'b0;
        readDelay   = 0;
        waitCnt     = 0;

        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("idle");

        $display("[TB] full frame, zero-wait handshakes");
        applyStimulus(0, 13, 1'b0, 1'b0);

        $display("[TB] first window stalled for 5 cycles");
        applyStimulus(0, 13, 1'b1, 1'b0);

        $display("[TB] reads delayed by 3 cycles");
        applyStimulus(3, 40, 1'b0, 1'b0);

        $display("[TB] reset during the second window column");
        applyAbort();
        applyStimulus(0, 13, 1'b0, 1'b0);

        $display("[TB] start and stray shift_done while busy");
        applyStimulus(0, 13, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
